// File: rtl/maze_tile_arbiter_if.sv
// Render/update/tile-RAM signal bundle for maze_tile_arbiter.
// The arbiter takes the slave view; whatever drives requests and models the RAM takes the master view.
interface maze_tile_arbiter_if #(
  parameter int TILE_W = 8
);
  logic              BLANK;
  logic              RD_REQ;
  logic [4:0]        RD_ADDR;
  logic              RD_VALID;
  logic [TILE_W-1:0] RD_DATA;
  logic              WR_REQ;
  logic [4:0]        WR_ADDR;
  logic [TILE_W-1:0] WR_DATA;
  logic              WR_READY;
  logic [4:0]        RAM_ADDR;
  logic [TILE_W-1:0] RAM_WDATA;
  logic              RAM_WE;
  logic [TILE_W-1:0] RAM_RDATA;
  logic              CLEAR_BUSY;

  modport master (
    output BLANK, RD_REQ, RD_ADDR, WR_REQ, WR_ADDR, WR_DATA, RAM_RDATA,
    input  RD_VALID, RD_DATA, WR_READY, RAM_ADDR, RAM_WDATA, RAM_WE, CLEAR_BUSY
  );

  modport slave (
    input  BLANK, RD_REQ, RD_ADDR, WR_REQ, WR_ADDR, WR_DATA, RAM_RDATA,
    output RD_VALID, RD_DATA, WR_READY, RAM_ADDR, RAM_WDATA, RAM_WE, CLEAR_BUSY
  );
endinterface

// File: rtl/maze_tile_arbiter.sv
// Single-port tile RAM arbiter: power-up clear sweep, then render reads vs. queued tile updates.
// Optional macro MAZE_ARB_BYPASS_EN: reads see the newest pending FIFO write to the same tile.
module maze_tile_arbiter #(
  parameter int TILE_W     = 8,
  parameter int NUM_TILES  = 20,
  parameter int FIFO_DEPTH = 4
) (
  input logic CLOCK,
  input logic RESET,
  maze_tile_arbiter_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [5:0]       NT    = 6'(NUM_TILES);
  localparam logic [4:0]       LAST  = 5'(NUM_TILES - 1);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [4:0]        sweep;
  logic [4:0]        fifo_addr [FIFO_DEPTH];
  logic [TILE_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              rd_valid_q, rd_grant_q, byp_hit_q;
  logic [TILE_W-1:0] byp_data_q;

  logic              fifo_empty, wr_ready, rd_in_range, wr_in_range;
  logic              read_go, pop, push;
  logic              byp_hit;
  logic [TILE_W-1:0] byp_data;

  assign fifo_empty  = (count == '0);
  assign wr_ready    = !RESET && (state == RUN) && (count < DEPTH);
  assign rd_in_range = ({1'b0, bus.RD_ADDR} < NT);
  assign wr_in_range = ({1'b0, bus.WR_ADDR} < NT);
  // Out-of-range writes are acknowledged but never queued, so they cannot reach RAM.
  assign push        = bus.WR_REQ && wr_ready && wr_in_range;

  // BLANK flips priority: visible area favours the renderer, blanking drains pending updates.
  always_comb begin
    read_go = 1'b0;
    pop     = 1'b0;
    if (state == RUN) begin
      if (bus.BLANK) begin
        pop     = !fifo_empty;
        read_go = fifo_empty && bus.RD_REQ && rd_in_range;
      end else begin
        read_go = bus.RD_REQ && rd_in_range;
        pop     = !bus.RD_REQ && !fifo_empty;
      end
    end
  end

  always_comb begin
    bus.RAM_WE    = 1'b0;
    bus.RAM_ADDR  = '0;
    bus.RAM_WDATA = '0;
    if (!RESET) begin
      if (state == CLEAR) begin
        bus.RAM_WE   = 1'b1;
        bus.RAM_ADDR = sweep;
      end else if (pop) begin
        bus.RAM_WE    = 1'b1;
        bus.RAM_ADDR  = fifo_addr[rd_ptr];
        bus.RAM_WDATA = fifo_data[rd_ptr];
      end else if (read_go) begin
        bus.RAM_ADDR = bus.RD_ADDR;
      end
    end
  end

`ifdef MAZE_ARB_BYPASS_EN
  // Walk oldest to newest so the last hit is the newest pending write.
  always_comb begin
    logic [PTR_W-1:0] idx;
    byp_hit  = 1'b0;
    byp_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (fifo_addr[idx] == bus.RD_ADDR)) begin
        byp_hit  = 1'b1;
        byp_data = fifo_data[idx];
      end
    end
  end
`else
  assign byp_hit  = 1'b0;
  assign byp_data = '0;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= CLEAR;
      sweep      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      rd_valid_q <= 1'b0;
      rd_grant_q <= 1'b0;
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      rd_valid_q <= bus.RD_REQ;
      rd_grant_q <= read_go;
      byp_hit_q  <= bus.RD_REQ && (state == RUN) && byp_hit;
      byp_data_q <= byp_data;

      if (state == CLEAR) begin
        sweep <= sweep + 5'd1;
        if (sweep == LAST) begin
          state <= RUN;
          sweep <= '0;
        end
      end

      if (push) begin
        fifo_addr[wr_ptr] <= bus.WR_ADDR;
        fifo_data[wr_ptr] <= bus.WR_DATA;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.WR_READY   = wr_ready;
  assign bus.CLEAR_BUSY = RESET || (state == CLEAR);
  assign bus.RD_VALID   = !RESET && rd_valid_q;
  assign bus.RD_DATA    = RESET      ? '0 :
                          byp_hit_q  ? byp_data_q :
                          rd_grant_q ? bus.RAM_RDATA : '0;

endmodule
